// File: rtl/dcache_pkg.sv
// Shared state type and line-geometry constants for the data-cache miss controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_REFILL    = 2'd3
  } dcache_state_t;

  localparam int LINE_OFF_W = 6;
  localparam logic [63:0] LINE_MASK = ~((64'd1 << LINE_OFF_W) - 64'd1);

endpackage

// File: rtl/dcache_perf_cnt.sv
// Hit / miss / write-back event counters for the data-cache controller; wrap modulo 2^CNT_WIDTH.
module dcache_perf_cnt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 hit_inc_i,
  input  logic                 miss_inc_i,
  input  logic                 wb_inc_i,
  output logic [CNT_WIDTH-1:0] hit_cnt_o,
  output logic [CNT_WIDTH-1:0] miss_cnt_o,
  output logic [CNT_WIDTH-1:0] wb_cnt_o
);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      if (hit_inc_i)  hit_cnt_o  <= hit_cnt_o + 1'b1;
      if (miss_inc_i) miss_cnt_o <= miss_cnt_o + 1'b1;
      if (wb_inc_i)   wb_cnt_o   <= wb_cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Miss-handling FSM for the 4-way write-back data cache: write back dirty victim, refill, replay.
// Optional performance counters are built when DCACHE_PERF_CNT_EN is defined.
//
// state        | meaning
// ST_IDLE      | no miss outstanding; stall follows the current miss combinationally
// ST_WRITEBACK | dirty victim being written to memory (bus write request held)
// ST_ALLOCATE  | line being fetched from memory (bus read request held)
// ST_REFILL    | one-cycle cache line write, then replay the access as a hit
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  mem_access_i,
  input  logic                  write_en_i,
  input  logic                  store_addr_ma_i,
  input  logic                  hit_i,
  input  logic                  dirty_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [ADDR_WIDTH-1:0] addr_wb_i,
  input  logic                  mem_done_i,
  input  logic                  mem_err_i,
  output logic                  stall_o,
  output logic                  block_we_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  access_fault_o
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o,
  output logic [CNT_WIDTH-1:0]  wb_cnt_o
`endif
);

  localparam logic [ADDR_WIDTH-1:0] FILL_MASK = LINE_MASK[ADDR_WIDTH-1:0];

  dcache_state_t         state_q;
  logic [ADDR_WIDTH-1:0] fill_addr_q;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic                  miss_s;

  assign miss_s    = mem_access_i & ~hit_i & ~store_addr_ma_i;
  assign line_addr = addr_i & FILL_MASK;

  // Stores are completed by the cache on the replayed hit, so the store flag is not needed here.
  logic unused_sink;
  assign unused_sink = write_en_i ^ (CNT_WIDTH > 0);

  // Reset forces the stall low immediately, even with a miss still presented.
  assign stall_o = ~arst_i & ((state_q == ST_IDLE) ? miss_s : 1'b1);

  // mem_addr_o doubles as the latched write-back address while in ST_WRITEBACK.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q        <= ST_IDLE;
      fill_addr_q    <= '0;
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      block_we_o     <= 1'b0;
      access_fault_o <= 1'b0;
    end else begin
      block_we_o     <= 1'b0;
      access_fault_o <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (miss_s) begin
            fill_addr_q <= line_addr;
            mem_req_o   <= 1'b1;
            if (dirty_i) begin
              mem_we_o   <= 1'b1;
              mem_addr_o <= addr_wb_i;
              state_q    <= ST_WRITEBACK;
            end else begin
              mem_we_o   <= 1'b0;
              mem_addr_o <= line_addr;
              state_q    <= ST_ALLOCATE;
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_err_i) begin
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            access_fault_o <= 1'b1;
            state_q        <= ST_IDLE;
          end else if (mem_done_i) begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= fill_addr_q;
            state_q    <= ST_ALLOCATE;
          end
        end
        ST_ALLOCATE: begin
          if (mem_err_i) begin
            mem_req_o      <= 1'b0;
            mem_addr_o     <= '0;
            access_fault_o <= 1'b1;
            state_q        <= ST_IDLE;
          end else if (mem_done_i) begin
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            block_we_o <= 1'b1;
            state_q    <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          state_q <= ST_IDLE;
        end
        default: begin
          mem_req_o  <= 1'b0;
          mem_we_o   <= 1'b0;
          mem_addr_o <= '0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic hit_inc, miss_inc, wb_inc;

  assign hit_inc  = (state_q == ST_IDLE) & mem_access_i & hit_i & ~stall_o;
  assign miss_inc = (state_q == ST_IDLE) & miss_s;
  assign wb_inc   = (state_q == ST_WRITEBACK) & mem_done_i;

  dcache_perf_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_perf_cnt (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .hit_inc_i  (hit_inc),
    .miss_inc_i (miss_inc),
    .wb_inc_i   (wb_inc),
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o),
    .wb_cnt_o   (wb_cnt_o)
  );
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized misses against a phase-level model.
module tb_dcache_ctrl;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic        mem_access_i = 1'b0, write_en_i = 1'b0, store_addr_ma_i = 1'b0;
  logic        hit_i = 1'b0, dirty_i = 1'b0, mem_done_i = 1'b0, mem_err_i = 1'b0;
  logic [63:0] addr_i = '0, addr_wb_i = '0;
  logic        stall_o, block_we_o, mem_req_o, mem_we_o, access_fault_o;
  logic [63:0] mem_addr_o;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_o, miss_cnt_o, wb_cnt_o;
`endif

  int errors = 0;
  int checks = 0;
  int exp_hit = 0, exp_miss = 0, exp_wb = 0;

  dcache_ctrl dut (
    .clk_i           (clk_i),
    .arst_i          (arst_i),
    .mem_access_i    (mem_access_i),
    .write_en_i      (write_en_i),
    .store_addr_ma_i (store_addr_ma_i),
    .hit_i           (hit_i),
    .dirty_i         (dirty_i),
    .addr_i          (addr_i),
    .addr_wb_i       (addr_wb_i),
    .mem_done_i      (mem_done_i),
    .mem_err_i       (mem_err_i),
    .stall_o         (stall_o),
    .block_we_o      (block_we_o),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .access_fault_o  (access_fault_o)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt_o       (hit_cnt_o),
    .miss_cnt_o      (miss_cnt_o),
    .wb_cnt_o        (wb_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  typedef struct {
    bit          stall, req, we, bwe, fault;
    logic [63:0] addr;
    bit          done, err, access, hit;
  } cyc_t;

  function automatic cyc_t mk(bit stall, bit req, bit we, bit bwe, bit fault,
                              logic [63:0] addr, bit done, bit err, bit access, bit hit);
    cyc_t c;
    c.stall = stall; c.req = req; c.we = we; c.bwe = bwe; c.fault = fault;
    c.addr = addr; c.done = done; c.err = err; c.access = access; c.hit = hit;
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input cyc_t c);
    check({tag, ".stall"}, stall_o, c.stall);
    check({tag, ".req"}, mem_req_o, c.req);
    check({tag, ".we"}, mem_we_o, c.we);
    check({tag, ".addr"}, mem_addr_o, c.addr);
    check({tag, ".bwe"}, block_we_o, c.bwe);
    check({tag, ".fault"}, access_fault_o, c.fault);
  endtask

  task automatic check_cnt(input string tag);
`ifdef DCACHE_PERF_CNT_EN
    check({tag, ".hit_cnt"}, hit_cnt_o, 32'(exp_hit));
    check({tag, ".miss_cnt"}, miss_cnt_o, 32'(exp_miss));
    check({tag, ".wb_cnt"}, wb_cnt_o, 32'(exp_wb));
`else
    check({tag, ".idle_req"}, mem_req_o, 1'b0);
`endif
  endtask

  // One non-missing cycle: hit, misaligned store, idle, or a stray done pulse.
  task automatic do_idle(input string tag, input bit access, input bit hit, input bit we,
                         input bit ma, input bit done);
    @(posedge clk_i); #1;
    mem_access_i = access; hit_i = hit; write_en_i = we; store_addr_ma_i = ma;
    mem_done_i = done; mem_err_i = 1'b0; dirty_i = 1'($urandom);
    addr_i = {$urandom, $urandom}; addr_wb_i = {$urandom, $urandom};
    if (access && hit) exp_hit++;
    @(negedge clk_i);
    check_outputs(tag, mk(0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0));
  endtask

  // err_at: 0 none, 1 error ends the write-back, 2 error ends the allocate.
  task automatic do_miss(input string tag, input logic [63:0] a, input logic [63:0] wba,
                         input bit dirty, input bit st, input int lat_wb, input int lat_al,
                         input int err_at);
    cyc_t q[$];
    bit   aborted = 0;
    int   stall_seen = 0, bwe_seen = 0;
    int   exp_stall, exp_bwe;
    q.push_back(mk(1, 0, 0, 0, 0, 64'h0, 0, 0, 1, 0));
    if (dirty) begin
      for (int i = 0; i < lat_wb; i++)
        q.push_back(mk(1, 1, 1, 0, 0, wba, (i == lat_wb-1) && err_at != 1,
                       (i == lat_wb-1) && err_at == 1, 1, 0));
      if (err_at == 1) begin
        q.push_back(mk(0, 0, 0, 0, 1, 64'h0, 0, 0, 0, 0));
        aborted = 1;
      end
    end
    if (!aborted) begin
      for (int i = 0; i < lat_al; i++)
        q.push_back(mk(1, 1, 0, 0, 0, a & ~64'h3F, (i == lat_al-1) && err_at != 2,
                       (i == lat_al-1) && err_at == 2, 1, 0));
      if (err_at == 2) begin
        q.push_back(mk(0, 0, 0, 0, 1, 64'h0, 0, 0, 0, 0));
      end else begin
        q.push_back(mk(1, 0, 0, 1, 0, 64'h0, 0, 0, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 64'h0, 0, 0, 1, 1));
      end
    end
    exp_stall = 1 + (dirty ? lat_wb : 0) + ((dirty && err_at == 1) ? 0 : lat_al)
              + ((err_at == 0 || (!dirty && err_at == 1)) ? 1 : 0);
    exp_bwe = (err_at == 0 || (!dirty && err_at == 1)) ? 1 : 0;
    exp_miss++;
    if (dirty && err_at != 1) exp_wb++;
    foreach (q[k]) begin
      @(posedge clk_i); #1;
      mem_access_i = q[k].access; hit_i = q[k].hit; write_en_i = st; store_addr_ma_i = 1'b0;
      mem_done_i = q[k].done; mem_err_i = q[k].err;
      if (k == 0 || q[k].hit) begin
        addr_i = a; addr_wb_i = wba; dirty_i = dirty;
      end else begin
        addr_i = {$urandom, $urandom}; addr_wb_i = {$urandom, $urandom}; dirty_i = 1'($urandom);
      end
      if (q[k].access && q[k].hit) exp_hit++;
      @(negedge clk_i);
      check_outputs(tag, q[k]);
      if (stall_o) stall_seen++;
      if (block_we_o) bwe_seen++;
    end
    check({tag, ".stall_cycles"}, 64'(stall_seen), 64'(exp_stall));
    check({tag, ".bwe_pulses"}, 64'(bwe_seen), 64'(exp_bwe));
  endtask

  initial begin
    #3;
    check_outputs("reset", mk(0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0));
    check_cnt("reset");
    @(posedge clk_i); #1;
    arst_i = 1'b0;

    do_idle("hit", 1, 1, 0, 0, 0);
    check_cnt("hit");
    do_idle("stray_done", 0, 0, 0, 0, 1);
    do_idle("after_stray", 0, 0, 0, 0, 0);

    do_miss("clean", 64'h1044, 64'h0, 0, 0, 0, 3, 0);
    check_cnt("clean");

    do_miss("dirty", 64'h3010, 64'h2000, 1, 1, 2, 2, 0);
    check_cnt("dirty");

    do_miss("err_alloc", 64'h5080, 64'h0, 0, 0, 0, 2, 2);
    do_idle("after_err", 0, 0, 0, 0, 0);

    do_idle("misaligned", 1, 0, 1, 1, 0);
    do_idle("misaligned_hit", 1, 1, 1, 1, 0);
    check_cnt("misaligned");

    do_miss("err_wb", 64'h7000, 64'h6FC0, 1, 1, 3, 1, 1);
    check_cnt("err_wb");

    for (int n = 0; n < 24; n++) begin
      int r, e;
      bit d;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        do_idle("rnd_hit", 1, 1, 1'($urandom), 0, 1'($urandom));
      end else if (r == 2) begin
        do_idle("rnd_ma", 1, 1'($urandom), 1, 1, 0);
      end else begin
        d = 1'($urandom);
        e = $urandom_range(0, 7);
        e = (e == 0) ? (d ? 1 : 2) : (e == 1) ? 2 : 0;
        do_miss("rnd_miss", {$urandom, $urandom}, {$urandom, $urandom} & ~64'h3F, d,
                1'($urandom), $urandom_range(1, 4), $urandom_range(1, 4), e);
      end
    end
    do_idle("rnd_end", 0, 0, 0, 0, 0);
    check_cnt("rnd_end");

    // Reset while the write-back request is outstanding.
    @(posedge clk_i); #1;
    mem_access_i = 1; hit_i = 0; dirty_i = 1; addr_i = 64'h9004; addr_wb_i = 64'h8800;
    mem_done_i = 0; mem_err_i = 0; store_addr_ma_i = 0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rst_pre.req", mem_req_o, 1'b1);
    check("rst_pre.we", mem_we_o, 1'b1);
    #2 arst_i = 1'b1;
    #1;
    check("rst_mid.req", mem_req_o, 1'b0);
    check("rst_mid.stall", stall_o, 1'b0);
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
    @(posedge clk_i); #1;
    arst_i = 1'b0; mem_access_i = 0;
    @(negedge clk_i);
    check_outputs("rst_after", mk(0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0));
    check_cnt("rst_after");
    do_idle("rst_idle", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
